// File: rtl/reg_write_arbiter.sv
// ----------------------------------------------------------------------------
// reg_write_arbiter
//
// Purpose:
//   Four-requester round-robin arbiter in front of a single downstream register
//   that captures on the falling clock edge. A winner is granted for one cycle,
//   and its data slice is latched at the end of that cycle. The following cycle
//   then issues a one-cycle Set to the register and a one-cycle Ack to the
//   winner. Every output comes straight from a flop.
//
// Optional feature:
//   RWA_LOCK_EN (macro). When it is defined, a requester that holds both Lock
//   and Req may keep ownership for up to RWA_LOCK_MAX back-to-back writes, one
//   write every 2 cycles. When it is undefined, the RWA_Lock_InBUS port and
//   the lock counter do not exist.
//
// Ports:
//   RWA_Clk            in   rising-edge clock
//   RWA_Reset          in   synchronous active-high reset
//   RWA_Req_InBUS      in   [3:0] write request, bit i = requester i
//   RWA_Data_InBUS     in   [4*W-1:0] requester i data in slice [i*W +: W]
//   RWA_Lock_InBUS     in   [3:0] lock request (RWA_LOCK_EN only)
//   RWA_Grant_OutBUS   out  [3:0] one-hot grant
//   RWA_Ack_OutBUS     out  [3:0] one-hot single-cycle write-done pulse
//   RWA_Set_Out        out  write strobe to the downstream register
//   RWA_Data_OutBUS    out  [W-1:0] write data to the downstream register
//   RWA_Busy_Out       out  high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module reg_write_arbiter #(
    parameter int unsigned RWA_DATA_WIDTH = 32,
    parameter int unsigned RWA_LOCK_MAX   = 8
) (
    input  logic                        RWA_Clk,
    input  logic                        RWA_Reset,
    input  logic [3:0]                  RWA_Req_InBUS,
    input  logic [4*RWA_DATA_WIDTH-1:0] RWA_Data_InBUS,
`ifdef RWA_LOCK_EN
    input  logic [3:0]                  RWA_Lock_InBUS,
`endif
    output logic [3:0]                  RWA_Grant_OutBUS,
    output logic [3:0]                  RWA_Ack_OutBUS,
    output logic                        RWA_Set_Out,
    output logic [RWA_DATA_WIDTH-1:0]   RWA_Data_OutBUS,
    output logic                        RWA_Busy_Out
);

    localparam int unsigned NUM_REQ = 4;

    // A lock limit of zero has no meaning.
    if (RWA_LOCK_MAX == 0) begin : g_bad_lock_max
        $error("reg_write_arbiter: RWA_LOCK_MAX must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [3:0]                grant_q, grant_d;
    logic [3:0]                ack_q,   ack_d;
    logic                      set_q,   set_d;
    logic [RWA_DATA_WIDTH-1:0] data_q,  data_d;
    logic                      busy_q,  busy_d;
    logic [1:0]                ptr_q,   ptr_d;
    logic [1:0]                win_q,   win_d;

    logic                      rr_valid_c;
    logic [1:0]                rr_win_c;
    logic                      win_req_c;
    logic                      lock_go_c;
    logic [RWA_DATA_WIDTH-1:0] slice_c [NUM_REQ];

    // Decoded one-hot vector for a requester index.
    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Split the flat data bus into per-requester slices.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign slice_c[gi] = RWA_Data_InBUS[gi*RWA_DATA_WIDTH +: RWA_DATA_WIDTH];
    end

    assign win_req_c = RWA_Req_InBUS[win_q];

    // Round-robin search that starts at ptr+1 and wraps. The loop runs from the
    // farthest offset down to the nearest, so the nearest requesting bit is
    // the last assignment and wins. Offset 4 wraps to ptr itself, which gives
    // it the lowest priority.
    always_comb begin
        rr_valid_c = 1'b0;
        rr_win_c   = ptr_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (RWA_Req_InBUS[ptr_q + 2'(k)]) begin
                rr_valid_c = 1'b1;
                rr_win_c   = ptr_q + 2'(k);
            end
        end
    end

`ifdef RWA_LOCK_EN
    localparam int unsigned LOCK_CNT_W = (RWA_LOCK_MAX > 1) ? $clog2(RWA_LOCK_MAX) : 1;

    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;

    // Keep ownership while the winner holds Lock and Req and budget remains.
    assign lock_go_c = RWA_Lock_InBUS[win_q] && win_req_c &&
                       (32'(lock_cnt_q) < (RWA_LOCK_MAX - 1));

    // Counts the locked writes made under the current ownership.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (state_q == ST_WRITE) begin
            lock_cnt_d = lock_go_c ? lock_cnt_q + LOCK_CNT_W'(1) : '0;
        end else if (state_q == ST_GRANT && !win_req_c) begin
            lock_cnt_d = '0;
        end
    end

    always_ff @(posedge RWA_Clk) begin
        if (RWA_Reset) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    assign lock_go_c = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge RWA_Clk) begin
        if (RWA_Reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            set_q   <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= 2'd3;
            win_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            set_q   <= set_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = rr_valid_c ? ST_GRANT : ST_IDLE;
            ST_GRANT: state_d = win_req_c ? ST_WRITE : ST_IDLE;
            ST_WRITE: state_d = lock_go_c ? ST_GRANT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of the output registers. Grant, Ack and Set are cleared by
    // default, so each one stays high for only the single cycle that follows
    // the edge that sets it.
    always_comb begin
        grant_d = '0;
        ack_d   = '0;
        set_d   = 1'b0;
        data_d  = data_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        busy_d  = (state_d != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (rr_valid_c) begin
                    win_d   = rr_win_c;
                    grant_d = onehot(rr_win_c);
                end
            end
            ST_GRANT: begin
                // If the request drops here, the grant is abandoned and the
                // pointer keeps its value.
                if (win_req_c) begin
                    data_d = slice_c[win_q];
                    set_d  = 1'b1;
                    ack_d  = onehot(win_q);
                end
            end
            ST_WRITE: begin
                ptr_d = win_q;
                if (lock_go_c) begin
                    grant_d = onehot(win_q);
                end
            end
            default: ;
        endcase
    end

    assign RWA_Grant_OutBUS = grant_q;
    assign RWA_Ack_OutBUS   = ack_q;
    assign RWA_Set_Out      = set_q;
    assign RWA_Data_OutBUS  = data_q;
    assign RWA_Busy_Out     = busy_q;

endmodule
